spi_master_sched: RTL and testbench
===================================

Name: spi_master_sched

Overview:
- Round-robin scheduler and SPI master engine that shares one SPI bus among NREQ on-chip requesters.
- Each requester submits one byte and a target slave index.
- Block arbitrates, drives sck/mosi/ssn in the selected CPOL/CPHA mode, captures miso, and returns the received byte with a one-cycle done pulse.
- Sits between system logic and the spi_slave-style peripherals on the board-level SPI bus.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NSLV, 4, number of slave-select lines (2..8); SW = clog2(NSLV).
- CLK_DIV, 4, clk cycles per sck half-period (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- spcon  in  8  bit0 = enable, bit2 = cpol, bit1 = cpha, others ignored
- req  in  NREQ  per-requester request, level, held until done
- req_data  in  8*NREQ  tx byte of requester i at [8i+7:8i]
- req_ssel  in  SW*NREQ  target slave index of requester i
- gnt  out  NREQ  one-hot grant, high from SETUP entry through HOLD
- done  out  1  one-cycle pulse, rx_data valid
- rx_data  out  8  byte received from miso, held until next done
- busy  out  1  high in any state other than IDLE
- sck  out  1  SPI clock
- mosi  out  1  master out
- miso  in  1  master in
- ssn  out  NSLV  active-low slave selects

Behaviour:
- Reset values (rst=0 at posedge clk): gnt=0, done=0, rx_data=0, busy=0, sck=0, mosi=0, ssn=all 1, rr pointer=0, state=IDLE. Reset mid-transfer aborts at once with no done pulse.
- Outside reset, sck idles at the cpol value latched at the last grant (0 after reset).
- IDLE: if spcon[0]=1 and req!=0, select the winner by round robin, searching from index ptr upward with wrap.
  - Latch winner's data, ssel, cpol and cpha.
  - Next cycle: gnt[winner]=1, busy=1, state=SETUP.
  - spcon[0]=0 means no grant; an in-flight transfer completes.
- SETUP (CLK_DIV cycles): ssn[ssel]=0, sck=cpol. If cpha=0, mosi=tx[7] from SETUP entry.
- XFER: 16 sck edges, each CLK_DIV cycles apart; the first edge comes at the end of SETUP.
  - Odd edges are leading, even edges are trailing.
  - cpha=0: sample miso on leading edges; shift the next bit onto mosi on trailing edges (none after edge 16).
  - cpha=1: drive mosi on leading edges (tx[7] on edge 1); sample miso on trailing edges.
  - Data is MSB first. Samples shift into rx_shift LSB-in.
- HOLD (CLK_DIV cycles): sck=cpol, ssn still low.
- On HOLD exit, in a single cycle: done=1, rx_data=rx_shift, ssn=all 1, gnt=0, busy=0, mosi=0, ptr=winner+1 mod NREQ, state=IDLE.
- Latency: request seen in IDLE at cycle t → gnt at t+1 → done at t+1+18*CLK_DIV (t+73 for CLK_DIV=4).
- At least one IDLE cycle separates back-to-back transfers. A request pending during the done cycle is arbitrated in that IDLE cycle.
- req deassert after grant is ignored; the transfer completes and done is still pulsed.
- req_data, req_ssel and spcon changes after grant do not affect the current transfer.
- ssel >= NSLV: transfer runs normally, no ssn line asserts, rx_data = whatever is sampled.
- gnt and ssn are always one-hot or zero. No combinational path from miso to any output.

Test Plan:
- Mode 0, CLK_DIV=4, req[0]=1, data 0xA5, ssel=1; slave model returns 0x3C:
  - mosi bits 1,0,1,0,0,1,0,1 on sck rising edges;
  - ssn=4'b1101 during the transfer;
  - done at t+73 with rx_data=0x3C;
  - gnt=4'b0001 from t+1 to t+72.
- Mode 3 (cpol=1, cpha=1), data 0x81, slave returns 0xFF: sck idles high, toggles 16 times, done with rx_data=0xFF; mosi MSB driven on the first (falling) edge.
- req=4'b1111 held continuously, ptr=0: grant order 0,1,2,3,0; exactly one IDLE cycle between done and the next gnt.
- req[2] dropped 10 cycles after grant: transfer still completes, done pulses, gnt[2] clears on the done cycle.
- rst=0 asserted at cycle 30 of a transfer: next cycle ssn=all 1, gnt=0, busy=0, sck=0, no done pulse; a fresh request afterward completes normally.
- spcon[0]=0 with req=4'b0100: no gnt for 50 cycles; set spcon[0]=1 → gnt=4'b0100 exactly one cycle later.

Source files
------------

// File: rtl/spi_master_sched.sv
// Round-robin scheduler and SPI master engine sharing one SPI bus among NREQ requesters.
// Each requester posts a byte and a slave index. The winner is latched, shifted out MSB first
// in the latched CPOL/CPHA mode, and the received byte is returned with a one-cycle done pulse.
//
// Ports:
//   clk, rst       system clock, synchronous active-low reset
//   spcon_i        [0] enable, [1] cpha, [2] cpol
//   req_i          per-requester level request, held until done
//   req_data_i     tx byte of requester i at [8i+7:8i]
//   req_ssel_i     slave index of requester i at [SW*i +: SW]
//   gnt_o          one-hot grant, SETUP through HOLD
//   done_o         one-cycle pulse, rx_data_o valid
//   rx_data_o      received byte, held until next done
//   busy_o         high whenever not idle
//   sck_o, mosi_o, miso_i, ssn_o   SPI bus (ssn_o active low)
module spi_master_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned NSLV    = 4,
  parameter int unsigned CLK_DIV = 4,
  localparam int unsigned SW     = $clog2(NSLV)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           spcon_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [8*NREQ-1:0]    req_data_i,
  input  logic [SW*NREQ-1:0]   req_ssel_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic                 done_o,
  output logic [7:0]           rx_data_o,
  output logic                 busy_o,
  output logic                 sck_o,
  output logic                 mosi_o,
  input  logic                 miso_i,
  output logic [NSLV-1:0]      ssn_o
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {StIdle, StSetup, StXfer, StHold} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, win_q, win_d;
  logic [SW-1:0] ssel_q, ssel_d;
  logic          cpol_q, cpol_d, cpha_q, cpha_d;
  logic          sck_q, sck_d, mosi_q, mosi_d, done_q, done_d;
  logic [7:0]    tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    edge_q, edge_d;  // sck edges already issued, 0..16

  // Round-robin search starting at ptr_q, wrapping at NREQ.
  logic          found;
  logic [PW-1:0] win_idx;
  logic [PW:0]   idx;
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(i);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!found && req_i[idx[PW-1:0]]) begin
        found   = 1'b1;
        win_idx = idx[PW-1:0];
      end
    end
  end

  logic       tick, edge_fire, do_sample;
  logic [7:0] win_data;
  assign tick      = (cnt_q == CW'(CLK_DIV - 1));
  // Edge 1 lands at the end of SETUP; in XFER the interval after edge 16 issues no edge.
  assign edge_fire = tick && ((state_q == StSetup) || (state_q == StXfer && edge_q != 5'd16));
  // Odd edges (edge_q even) are leading; sample on leading for cpha=0, trailing for cpha=1.
  assign do_sample = ~edge_q[0] ^ cpha_q;
  assign win_data  = req_data_i[win_idx*8 +: 8];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    ssel_d    = ssel_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;

    unique case (state_q)
      StIdle: begin
        if (spcon_i[0] && found) begin
          state_d = StSetup;
          win_d   = win_idx;
          ssel_d  = req_ssel_i[win_idx*SW +: SW];
          cpol_d  = spcon_i[2];
          cpha_d  = spcon_i[1];
          sck_d   = spcon_i[2];
          cnt_d   = '0;
          edge_d  = '0;
          rx_d    = '0;
          if (!spcon_i[1]) begin
            mosi_d = win_data[7];
            tx_d   = {win_data[6:0], 1'b0};
          end else begin
            mosi_d = 1'b0;
            tx_d   = win_data;
          end
        end
      end
      StSetup, StXfer: begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        if (tick && state_q == StSetup) state_d = StXfer;
        if (tick && state_q == StXfer && edge_q == 5'd16) state_d = StHold;
      end
      StHold: begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        if (tick) begin
          state_d   = StIdle;
          done_d    = 1'b1;
          rx_data_d = rx_q;
          mosi_d    = 1'b0;
          ptr_d     = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (edge_fire) begin
      sck_d  = ~sck_q;
      edge_d = edge_q + 5'd1;
      if (do_sample) begin
        rx_d = {rx_q[6:0], miso_i};
      end else if (cpha_q || edge_q != 5'd15) begin
        // No shift after the final trailing edge in cpha=0.
        mosi_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      win_q     <= '0;
      ssel_q    <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      cnt_q     <= '0;
      edge_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      ssel_q    <= ssel_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
    end
  end

  // Grant and selects decode from registered state only; an out-of-range ssel asserts nothing.
  always_comb begin
    gnt_o = '0;
    ssn_o = '1;
    if (state_q != StIdle) begin
      gnt_o[win_q] = 1'b1;
      for (int unsigned j = 0; j < NSLV; j++) begin
        if (ssel_q == SW'(j)) ssn_o[j] = 1'b0;
      end
    end
  end

  assign busy_o    = (state_q != StIdle);
  assign done_o    = done_q;
  assign rx_data_o = rx_data_q;
  assign sck_o     = sck_q;
  assign mosi_o    = mosi_q;

endmodule

// File: tb/tb_spi_master_sched.sv
// Directed bench for spi_master_sched with a behavioural SPI slave on the bus.
module tb_spi_master_sched;
  localparam int NREQ    = 4;
  localparam int NSLV    = 4;
  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  spcon;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [7:0]  req_ssel;
  logic [3:0]  gnt;
  logic        done;
  logic [7:0]  rx_data;
  logic        busy, sck, mosi;
  logic        miso = 1'b0;
  logic [3:0]  ssn;

  always #5 clk = ~clk;

  spi_master_sched #(
    .NREQ    (NREQ),
    .NSLV    (NSLV),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .spcon_i    (spcon),
    .req_i      (req),
    .req_data_i (req_data),
    .req_ssel_i (req_ssel),
    .gnt_o      (gnt),
    .done_o     (done),
    .rx_data_o  (rx_data),
    .busy_o     (busy),
    .sck_o      (sck),
    .mosi_o     (mosi),
    .miso_i     (miso),
    .ssn_o      (ssn)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural slave: shifts slv_tx out on miso, collects mosi into slv_rx.
  logic       slv_cpol = 1'b0, slv_cpha = 1'b0;
  logic [7:0] slv_tx = '0, slv_sh = '0, slv_rx = '0;
  logic       slv_act, prev_act = 1'b0, prev_sck = 1'b0;
  int         sck_edges = 0;
  assign slv_act = (ssn != 4'hF);

  always @(sck or slv_act) begin
    if (slv_act === 1'b1 && prev_act !== 1'b1) begin
      slv_sh = slv_tx;
      slv_rx = '0;
      if (!slv_cpha) begin
        miso   = slv_sh[7];
        slv_sh = {slv_sh[6:0], 1'b0};
      end
    end else if (slv_act === 1'b1 && sck !== prev_sck) begin
      sck_edges++;
      if ((sck !== slv_cpol) ^ slv_cpha) begin
        slv_rx = {slv_rx[6:0], mosi};
      end else begin
        miso   = slv_sh[7];
        slv_sh = {slv_sh[6:0], 1'b0};
      end
    end
    prev_act = slv_act;
    prev_sck = sck;
  end

  // Runs one transfer from the cycle after the request is presented up to its done cycle.
  // drop_at > 0 removes req, spcon and req_data at that cycle after grant.
  task automatic do_xfer(input string tag, input logic [3:0] exp_gnt, input logic [3:0] exp_ssn,
                         input logic exp_cpol, input logic [7:0] exp_tx,
                         input logic [7:0] exp_rx, input int drop_at);
    int done_at = -1;
    int e0 = sck_edges;
    for (int k = 1; k <= 100 && done_at < 0; k++) begin
      @(negedge clk);
      if (k == drop_at) begin
        req      = '0;
        spcon    = '0;
        req_data = '0;
      end
      if (done === 1'b1) done_at = k;
      else if (k == 1) begin
        check_eq({tag, ".gnt_first"}, gnt, exp_gnt);
        check_eq({tag, ".busy"}, busy, 1'b1);
      end else if (k == 2) begin
        check_eq({tag, ".ssn"}, ssn, exp_ssn);
        check_eq({tag, ".sck_setup"}, sck, exp_cpol);
      end else if (k == 5) begin
        check_eq({tag, ".mosi_msb"}, mosi, exp_tx[7]);
      end else if (k == 72) begin
        check_eq({tag, ".gnt_last"}, gnt, exp_gnt);
      end
    end
    check_eq({tag, ".latency"}, done_at, 73);
    check_eq({tag, ".rx_data"}, rx_data, exp_rx);
    check_eq({tag, ".slave_rx"}, slv_rx, exp_tx);
    check_eq({tag, ".sck_edges"}, sck_edges - e0, 16);
    check_eq({tag, ".gnt_done"}, gnt, 4'b0000);
    check_eq({tag, ".ssn_done"}, ssn, 4'hF);
    check_eq({tag, ".busy_done"}, busy, 1'b0);
    check_eq({tag, ".sck_idle"}, sck, exp_cpol);
  endtask

  initial begin
    int   order[5] = '{0, 1, 2, 3, 0};
    logic seen;

    rst = 1'b0; spcon = '0; req = '0; req_data = '0; req_ssel = '0;
    repeat (3) @(negedge clk);
    check_eq("rst.gnt", gnt, 4'b0000);
    check_eq("rst.done", done, 1'b0);
    check_eq("rst.rx_data", rx_data, 8'h00);
    check_eq("rst.busy", busy, 1'b0);
    check_eq("rst.sck", sck, 1'b0);
    check_eq("rst.mosi", mosi, 1'b0);
    check_eq("rst.ssn", ssn, 4'hF);
    rst = 1'b1;
    @(negedge clk);

    // Mode 0, requester 0 -> slave 1.
    slv_cpol = 1'b0; slv_cpha = 1'b0; slv_tx = 8'h3C;
    spcon = 8'h01; req_data[7:0] = 8'hA5; req_ssel[1:0] = 2'd1; req = 4'b0001;
    do_xfer("m0", 4'b0001, 4'b1101, 1'b0, 8'hA5, 8'h3C, 0);
    req = '0;
    @(negedge clk);
    check_eq("m0.done_pulse", done, 1'b0);
    check_eq("m0.rx_hold", rx_data, 8'h3C);

    // Mode 3, requester 1 -> slave 2.
    slv_cpol = 1'b1; slv_cpha = 1'b1; slv_tx = 8'hFF;
    spcon = 8'h07; req_data[15:8] = 8'h81; req_ssel[3:2] = 2'd2; req = 4'b0010;
    do_xfer("m3", 4'b0010, 4'b1011, 1'b1, 8'h81, 8'hFF, 0);
    req = '0;
    @(negedge clk);
    check_eq("m3.sck_idle_high", sck, 1'b1);

    // Round robin from ptr=0 with all requesters held.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    slv_cpol = 1'b0; slv_cpha = 1'b0; slv_tx = 8'h5A;
    spcon = 8'h01; req_data = 32'h44332211; req_ssel = 8'b11_10_01_00; req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      do_xfer($sformatf("rr%0d", n), 4'(1 << order[n]), ~4'(1 << order[n]), 1'b0,
              8'(8'h11 * (order[n] + 1)), 8'h5A, 0);
    end
    req = '0;

    // Requester 2 drops req/spcon/data 10 cycles after grant; transfer still completes.
    slv_tx = 8'hC3;
    req = 4'b0100;
    do_xfer("drop", 4'b0100, 4'b1011, 1'b0, 8'h33, 8'hC3, 10);

    // Disabled: no grant for 50 cycles, then grant one cycle after enable.
    req_data = 32'h44332211; spcon = 8'h00; req = 4'b0100;
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (gnt != 4'b0000 || busy) seen = 1'b1;
    end
    check_eq("dis.no_gnt", seen, 1'b0);
    spcon = 8'h01;
    do_xfer("en", 4'b0100, 4'b1011, 1'b0, 8'h33, 8'hC3, 0);
    req = '0;
    @(negedge clk);

    // Reset 30 cycles into a mode-3 transfer, then a fresh mode-0 transfer.
    slv_cpol = 1'b1; slv_cpha = 1'b1; slv_tx = 8'h96;
    spcon = 8'h07; req = 4'b0001;
    seen = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort.ssn", ssn, 4'hF);
    check_eq("abort.gnt", gnt, 4'b0000);
    check_eq("abort.busy", busy, 1'b0);
    check_eq("abort.sck", sck, 1'b0);
    check_eq("abort.done", {seen, done}, 2'b00);
    rst = 1'b1;
    slv_cpol = 1'b0; slv_cpha = 1'b0; slv_tx = 8'h69;
    spcon = 8'h01;
    do_xfer("fresh", 4'b0001, 4'b1110, 1'b0, 8'h11, 8'h69, 0);
    req = '0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
